// File: rtl/command_driver.sv
// command_driver: queues host requests and issues them on the DDR2 controller command bus.
// Optional CMD_DRV_FILTER_EN drops NOP requests at the FIFO input and counts them on rej_cnt.
module command_driver #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_cmd,
    input  logic [1:0]  req_sz,
    input  logic [2:0]  req_op,
    input  logic [24:0] req_addr,
    input  logic [15:0] req_data,
    input  logic        wd_valid,
    output logic        wd_ready,
    input  logic [15:0] wd_data,
    input  logic        ready,
    input  logic        fetching,
    output logic [2:0]  cmd,
    output logic [1:0]  sz,
    output logic [2:0]  op,
    output logic [15:0] din,
    output logic [24:0] addr,
`ifdef CMD_DRV_FILTER_EN
    output logic [15:0] rej_cnt,
`endif
    output logic        busy,
    output logic        underrun
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, ISSUE, BLW_DATA} state_t;
    state_t      r_state, w_next;
    logic [48:0] r_mem [DEPTH];
    logic [AW:0] r_wr, r_rd;
    logic [48:0] w_head;
    logic [2:0]  w_hcmd;
    logic        w_empty, w_full, w_push, w_pop, w_fetch;
    logic [2:0]  r_cmd, r_op;
    logic [1:0]  r_sz;
    logic [15:0] r_din;
    logic [24:0] r_addr;
    logic [4:0]  r_beats;
    logic        r_underrun;

    assign w_head    = r_mem[r_rd[AW-1:0]];
    assign w_hcmd    = w_head[48:46];
    assign w_empty   = r_wr == r_rd;
    assign w_full    = (r_wr[AW-1:0] == r_rd[AW-1:0]) && (r_wr[AW] != r_rd[AW]);
    // a pop in the same cycle frees a slot, so a full FIFO can still accept
    assign req_ready = !w_full || w_pop;
`ifdef CMD_DRV_FILTER_EN
    logic        w_nop;
    logic [15:0] r_rej;
    assign w_nop   = req_cmd == 3'd0 || req_cmd == 3'd7;
    assign w_push  = req_valid && req_ready && !w_nop;
    assign rej_cnt = r_rej;
    always_ff @(posedge clk)
        if (reset)
            r_rej <= '0;
        else if (req_valid && req_ready && w_nop && r_rej != 16'hFFFF)
            r_rej <= r_rej + 16'd1;
`else
    assign w_push = req_valid && req_ready;
`endif
    assign cmd      = r_cmd;
    assign sz       = r_sz;
    assign op       = r_op;
    assign din      = r_din;
    assign addr     = r_addr;
    assign underrun = r_underrun;
    assign busy     = !w_empty || r_state != IDLE;

    always_ff @(posedge clk)
        r_state <= reset ? IDLE : w_next;

    always_comb begin
        w_next   = r_state;
        w_pop    = 1'b0;
        w_fetch  = 1'b0;
        wd_ready = 1'b0;
        if (!reset)
            case (r_state)
                IDLE:
                    if (!w_empty && ready && (w_hcmd != 3'd4 || wd_valid)) begin
                        w_pop    = 1'b1;
                        wd_ready = w_hcmd == 3'd4;
                        w_next   = ISSUE;
                    end
                ISSUE: w_next = r_cmd == 3'd4 ? BLW_DATA : IDLE;
                BLW_DATA:
                    if (fetching) begin
                        w_fetch  = 1'b1;
                        wd_ready = wd_valid;
                        w_next   = r_beats == 5'd1 ? IDLE : BLW_DATA;
                    end
                default: w_next = IDLE;
            endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr       <= '0;
            r_rd       <= '0;
            r_cmd      <= '0;
            r_sz       <= '0;
            r_op       <= '0;
            r_din      <= '0;
            r_addr     <= '0;
            r_beats    <= '0;
            r_underrun <= 1'b0;
        end else begin
            if (w_push)
                r_mem[r_wr[AW-1:0]] <= {req_cmd, req_sz, req_op, req_addr, req_data};
            r_wr <= r_wr + {{AW{1'b0}}, w_push};
            r_rd <= r_rd + {{AW{1'b0}}, w_pop};
            if (w_pop) begin
                r_cmd  <= w_hcmd == 3'd7 ? 3'd0 : w_hcmd;
                r_sz   <= w_head[45:44];
                r_op   <= w_head[43:41];
                r_addr <= w_head[40:16];
                r_din  <= w_hcmd == 3'd4 ? wd_data : w_head[15:0];
            end else if (r_state == ISSUE) begin
                r_cmd   <= 3'd0;
                r_beats <= {r_sz, 3'b111};
            end else if (w_fetch) begin
                // a starved beat still counts so the burst length stays fixed
                r_beats <= r_beats - 5'd1;
                if (wd_valid)
                    r_din <= wd_data;
                else
                    r_underrun <= 1'b1;
            end
        end
    end
endmodule
